// File: rtl/aes_axis_pkg.sv
// Shared types and constants for the AES output-side stream sequencer.
// Block geometry: 128-bit AES blocks split into four 32-bit stream words.
package aes_axis_pkg;

  localparam int AES_BLK_W         = 128;
  localparam int AES_WORDS_PER_BLK = 4;
  localparam int AES_WORD_W        = AES_BLK_W / AES_WORDS_PER_BLK;
  localparam int AES_IDX_W         = 2;

  // Index of the final word of a block (the one that closes the block).
  localparam logic [AES_IDX_W-1:0] LAST_WORD_IDX = AES_IDX_W'(AES_WORDS_PER_BLK - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BLK = 2'd1,
    SEND     = 2'd2
  } out_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/aes_axis_out_ctrl_if.sv
// AXI-Stream word channel between the AES output sequencer and its sink.
interface aes_axis_out_ctrl_if #(
  parameter int DATA_W = 32
) ();

  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;

  modport master (
    output tvalid,
    output tlast,
    output tdata,
    output tstrb,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tlast,
    input  tdata,
    input  tstrb,
    output tready
  );

endinterface

// File: rtl/aes_blk_serializer.sv
// Holds one 128-bit AES block and presents it as a registered 32-bit word,
// most significant word first. 'load' captures a new block and presents its
// word 0; 'advance' steps to the next word. Load wins when both fire, which
// is how a back-to-back block replaces the word after the last one.
module aes_blk_serializer
  import aes_axis_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [AES_BLK_W-1:0]  blk_data,
  output logic [AES_WORD_W-1:0] tdata,
  output logic [AES_IDX_W-1:0]  word_idx
);

  logic [AES_BLK_W-1:0]  hold_reg;
  logic [AES_IDX_W-1:0]  word_idx_reg;
  logic [AES_IDX_W-1:0]  word_idx_next;
  logic [AES_WORD_W-1:0] tdata_reg;
  logic [AES_WORD_W-1:0] hold_words [AES_WORDS_PER_BLK];

  // Word gi of the held block, word 0 being the most significant slice.
  genvar gi;
  generate
    for (gi = 0; gi < AES_WORDS_PER_BLK; gi++) begin : g_word
      assign hold_words[gi] = hold_reg[AES_BLK_W-1-AES_WORD_W*gi -: AES_WORD_W];
    end
  endgenerate

  assign word_idx_next = word_idx_reg + AES_IDX_W'(1);

  // Capture blocks and step the registered output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg     <= '0;
      word_idx_reg <= '0;
      tdata_reg    <= '0;
    end else if (load) begin
      hold_reg     <= blk_data;
      word_idx_reg <= '0;
      tdata_reg    <= blk_data[AES_BLK_W-1 -: AES_WORD_W];
    end else if (advance) begin
      word_idx_reg <= word_idx_next;
      tdata_reg    <= hold_words[word_idx_next];
    end
  end

  assign tdata    = tdata_reg;
  assign word_idx = word_idx_reg;

endmodule

// File: rtl/aes_axis_out_ctrl.sv
// Output-side sequencer of the AES engine: accepts 128-bit result blocks
// from the core and streams each as four 32-bit AXI-Stream words, MSW first,
// with TLAST on the final word of a packet of pkt_blocks blocks.
// Optional feature macro: AXIS_OUT_STATS_EN adds saturating stat_words /
// stat_stalls counters.
module aes_axis_out_ctrl
  import aes_axis_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int PKT_BLOCKS_W         = 16
) (
  input  logic                    m00_axis_aclk,
  input  logic                    m00_axis_aresetn,
  input  logic                    pkt_start,
  input  logic [PKT_BLOCKS_W-1:0] pkt_blocks,
  output logic                    pkt_busy,
  input  logic                    blk_valid,
  output logic                    blk_ready,
  input  logic [AES_BLK_W-1:0]    blk_data,
  aes_axis_out_ctrl_if.master     m00_axis
`ifdef AXIS_OUT_STATS_EN
  ,
  output logic [31:0]             stat_words,
  output logic [31:0]             stat_stalls
`endif
);

  generate
    if (C_M_AXIS_TDATA_WIDTH != AES_WORD_W) begin : g_bad_width
      $fatal(1, "aes_axis_out_ctrl: only a 32-bit master stream is supported");
    end
  endgenerate

  out_state_t              state_reg;
  logic [PKT_BLOCKS_W-1:0] rem_reg;
  logic                    tvalid_reg;
  logic                    tlast_reg;
  logic                    pkt_busy_reg;
  logic                    blk_ready_w;
  logic                    word_hs;
  logic                    blk_hs;
  logic                    on_last_word;
  logic                    last_blk;
  logic [AES_WORD_W-1:0]   tdata_w;
  logic [AES_IDX_W-1:0]    word_idx_w;

  assign word_hs      = tvalid_reg && m00_axis.tready;
  assign blk_hs       = blk_valid && blk_ready_w;
  assign on_last_word = (word_idx_w == LAST_WORD_IDX);
  assign last_blk     = (rem_reg == PKT_BLOCKS_W'(1));

  // Block acceptance: always while waiting, and during the closing word of a
  // non-final block only when that word is taken, so blocks run back to back.
  always_comb begin
    blk_ready_w = 1'b0;
    case (state_reg)
      WAIT_BLK: blk_ready_w = 1'b1;
      SEND:     blk_ready_w = on_last_word && m00_axis.tready && !last_blk;
      default:  blk_ready_w = 1'b0;
    endcase
  end

  // Packet sequencer: block count, stream valid/last and busy flag.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_reg    <= IDLE;
      rem_reg      <= '0;
      tvalid_reg   <= 1'b0;
      tlast_reg    <= 1'b0;
      pkt_busy_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pkt_start && (pkt_blocks != '0)) begin
            state_reg    <= WAIT_BLK;
            rem_reg      <= pkt_blocks;
            pkt_busy_reg <= 1'b1;
          end
        end
        WAIT_BLK: begin
          if (blk_hs) begin
            state_reg  <= SEND;
            tvalid_reg <= 1'b1;
            tlast_reg  <= 1'b0;
          end
        end
        SEND: begin
          if (word_hs) begin
            if (word_idx_w == LAST_WORD_IDX - AES_IDX_W'(1)) begin
              // The next word closes this block; it ends the packet if this
              // is the final block.
              tlast_reg <= last_blk;
            end else if (on_last_word) begin
              rem_reg   <= rem_reg - PKT_BLOCKS_W'(1);
              tlast_reg <= 1'b0;
              if (last_blk) begin
                state_reg    <= IDLE;
                tvalid_reg   <= 1'b0;
                pkt_busy_reg <= 1'b0;
              end else if (blk_hs) begin
                tvalid_reg <= 1'b1;
              end else begin
                state_reg  <= WAIT_BLK;
                tvalid_reg <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_reg    <= IDLE;
          tvalid_reg   <= 1'b0;
          tlast_reg    <= 1'b0;
          pkt_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  aes_blk_serializer u_serializer (
    .clk      (m00_axis_aclk),
    .rst_n    (m00_axis_aresetn),
    .load     (blk_hs),
    .advance  (word_hs),
    .blk_data (blk_data),
    .tdata    (tdata_w),
    .word_idx (word_idx_w)
  );

  assign m00_axis.tvalid = tvalid_reg;
  assign m00_axis.tlast  = tlast_reg;
  assign m00_axis.tdata  = tdata_w;
  assign m00_axis.tstrb  = tvalid_reg ? '1 : '0;
  assign pkt_busy        = pkt_busy_reg;
  assign blk_ready       = blk_ready_w;

`ifdef AXIS_OUT_STATS_EN
  logic [31:0] stat_words_reg;
  logic [31:0] stat_stalls_reg;

  // Count accepted words and cycles a valid word waits on the sink.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      stat_words_reg  <= '0;
      stat_stalls_reg <= '0;
    end else begin
      if (word_hs) begin
        stat_words_reg <= sat_inc32(stat_words_reg);
      end
      if (tvalid_reg && !m00_axis.tready) begin
        stat_stalls_reg <= sat_inc32(stat_stalls_reg);
      end
    end
  end

  assign stat_words  = stat_words_reg;
  assign stat_stalls = stat_stalls_reg;
`endif

endmodule

// File: tb/tb_aes_axis_out_ctrl.sv
// Directed bench for aes_axis_out_ctrl: per-cycle vector table for the plain
// packet cases, hand-written sequences for stalls, ignored restarts and reset.
module tb_aes_axis_out_ctrl;

  logic         clk;
  logic         rst_n;
  logic         pkt_start;
  logic [15:0]  pkt_blocks;
  logic         pkt_busy;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
`ifdef AXIS_OUT_STATS_EN
  logic [31:0]  stat_words;
  logic [31:0]  stat_stalls;
  logic [31:0]  base_w;
  logic [31:0]  base_s;
`endif

  aes_axis_out_ctrl_if #(.DATA_W(32)) m00_if ();

  aes_axis_out_ctrl #(
    .C_M_AXIS_TDATA_WIDTH (32),
    .PKT_BLOCKS_W         (16)
  ) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .pkt_start        (pkt_start),
    .pkt_blocks       (pkt_blocks),
    .pkt_busy         (pkt_busy),
    .blk_valid        (blk_valid),
    .blk_ready        (blk_ready),
    .blk_data         (blk_data),
    .m00_axis         (m00_if)
`ifdef AXIS_OUT_STATS_EN
    ,
    .stat_words       (stat_words),
    .stat_stalls      (stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         start;
    logic [15:0]  nblk;
    logic         bvalid;
    logic [127:0] bdata;
    logic         tready;
    logic         e_busy;
    logic         e_bready;
    logic         e_tvalid;
    logic         e_tlast;
    logic [31:0]  e_tdata;
  } vec_t;

  vec_t vecs[$];

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
  localparam logic [127:0] BLK_C = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

  logic [31:0] a_w [4];
  logic [31:0] b_w [4];
  logic [31:0] c_w [4];

  int          n_cmp;
  int          n_fail;
  int          nw;
  int          nl;
  int          nacc;
  int          stalls;
  logic        have_prev;
  logic        take;
  logic [31:0] prev_d;
  logic        prev_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic s, input logic [15:0] n, input logic bv,
                              input logic [127:0] bd, input logic tr, input logic busy,
                              input logic br, input logic tv, input logic tl,
                              input logic [31:0] td);
    vec_t v;
    v.start = s;  v.nblk = n;  v.bvalid = bv; v.bdata = bd; v.tready = tr;
    v.e_busy = busy; v.e_bready = br; v.e_tvalid = tv; v.e_tlast = tl; v.e_tdata = td;
    vecs.push_back(v);
  endfunction

  // One line per accepted stream word.
  always @(posedge clk) begin
    if (rst_n && m00_if.tvalid && m00_if.tready)
      $display("  xfer tdata=%h tlast=%b", m00_if.tdata, m00_if.tlast);
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    a_w[0] = 32'h00112233; a_w[1] = 32'h44556677; a_w[2] = 32'h8899AABB; a_w[3] = 32'hCCDDEEFF;
    b_w[0] = 32'hDEADBEEF; b_w[1] = 32'h01234567; b_w[2] = 32'h89ABCDEF; b_w[3] = 32'hFEEDFACE;
    c_w[0] = 32'h0F1E2D3C; c_w[1] = 32'h4B5A6978; c_w[2] = 32'h8796A5B4; c_w[3] = 32'hC3D2E1F0;

    // single block packet
    add(1, 1, 1, BLK_A, 1,  0, 0, 0, 0, 32'h0);
    add(0, 0, 1, BLK_A, 1,  1, 1, 0, 0, 32'h0);
    add(0, 0, 1, BLK_A, 1,  1, 0, 1, 0, 32'h00112233);
    add(0, 0, 1, BLK_A, 1,  1, 0, 1, 0, 32'h44556677);
    add(0, 0, 1, BLK_A, 1,  1, 0, 1, 0, 32'h8899AABB);
    add(0, 0, 1, BLK_A, 1,  1, 0, 1, 1, 32'hCCDDEEFF);
    add(0, 0, 0, BLK_A, 1,  0, 0, 0, 0, 32'h0);
    // three blocks back to back
    add(1, 3, 1, BLK_A, 1,  0, 0, 0, 0, 32'h0);
    add(0, 0, 1, BLK_A, 1,  1, 1, 0, 0, 32'h0);
    add(0, 0, 1, BLK_B, 1,  1, 0, 1, 0, 32'h00112233);
    add(0, 0, 1, BLK_B, 1,  1, 0, 1, 0, 32'h44556677);
    add(0, 0, 1, BLK_B, 1,  1, 0, 1, 0, 32'h8899AABB);
    add(0, 0, 1, BLK_B, 1,  1, 1, 1, 0, 32'hCCDDEEFF);
    add(0, 0, 1, BLK_C, 1,  1, 0, 1, 0, 32'hDEADBEEF);
    add(0, 0, 1, BLK_C, 1,  1, 0, 1, 0, 32'h01234567);
    add(0, 0, 1, BLK_C, 1,  1, 0, 1, 0, 32'h89ABCDEF);
    add(0, 0, 1, BLK_C, 1,  1, 1, 1, 0, 32'hFEEDFACE);
    add(0, 0, 1, BLK_C, 1,  1, 0, 1, 0, 32'h0F1E2D3C);
    add(0, 0, 1, BLK_C, 1,  1, 0, 1, 0, 32'h4B5A6978);
    add(0, 0, 1, BLK_C, 1,  1, 0, 1, 0, 32'h8796A5B4);
    add(0, 0, 1, BLK_C, 1,  1, 0, 1, 1, 32'hC3D2E1F0);
    add(0, 0, 0, BLK_C, 1,  0, 0, 0, 0, 32'h0);
    // zero-length request is ignored; idle never accepts a block
    add(1, 0, 1, BLK_C, 1,  0, 0, 0, 0, 32'h0);
    add(0, 0, 1, BLK_C, 1,  0, 0, 0, 0, 32'h0);
    add(0, 0, 1, BLK_C, 1,  0, 0, 0, 0, 32'h0);
    add(0, 0, 1, BLK_C, 1,  0, 0, 0, 0, 32'h0);

    // reset state
    rst_n = 1'b0; pkt_start = 1'b0; pkt_blocks = '0; blk_valid = 1'b0;
    blk_data = '0; m00_if.tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy",   {31'd0, pkt_busy}, 32'd0);
    chk("rst.bready", {31'd0, blk_ready}, 32'd0);
    chk("rst.tvalid", {31'd0, m00_if.tvalid}, 32'd0);
    chk("rst.tlast",  {31'd0, m00_if.tlast}, 32'd0);
    chk("rst.tdata",  m00_if.tdata, 32'd0);
    chk("rst.tstrb",  {28'd0, m00_if.tstrb}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // vector table
    for (int i = 0; i < vecs.size(); i++) begin
      pkt_start = vecs[i].start; pkt_blocks = vecs[i].nblk;
      blk_valid = vecs[i].bvalid; blk_data = vecs[i].bdata;
      m00_if.tready = vecs[i].tready;
      #2;
      chk($sformatf("v%0d.busy", i),   {31'd0, pkt_busy}, {31'd0, vecs[i].e_busy});
      chk($sformatf("v%0d.bready", i), {31'd0, blk_ready}, {31'd0, vecs[i].e_bready});
      chk($sformatf("v%0d.tvalid", i), {31'd0, m00_if.tvalid}, {31'd0, vecs[i].e_tvalid});
      chk($sformatf("v%0d.tlast", i),  {31'd0, m00_if.tlast}, {31'd0, vecs[i].e_tlast});
      chk($sformatf("v%0d.tstrb", i),  {28'd0, m00_if.tstrb}, vecs[i].e_tvalid ? 32'hF : 32'h0);
      if (vecs[i].e_tvalid)
        chk($sformatf("v%0d.tdata", i), m00_if.tdata, vecs[i].e_tdata);
      cyc();
    end
    pkt_start = 1'b0; blk_valid = 1'b0;

    // slow sink: tready once every 16 cycles, two blocks
`ifdef AXIS_OUT_STATS_EN
    base_w = stat_words; base_s = stat_stalls;
`endif
    pkt_start = 1'b1; pkt_blocks = 16'd2; blk_valid = 1'b1; blk_data = BLK_A;
    m00_if.tready = 1'b0;
    cyc();
    pkt_start = 1'b0; pkt_blocks = '0;
    nw = 0; stalls = 0; nacc = 0; have_prev = 1'b0; prev_d = '0; prev_l = 1'b0;
    for (int c = 0; c < 400 && nw < 8; c++) begin
      m00_if.tready = ((c % 16) == 15);
      #2;
      take = blk_valid && blk_ready;
      if (take) nacc++;
      if (m00_if.tvalid) begin
        if (have_prev) begin
          chk($sformatf("t3.hold_data%0d", c), m00_if.tdata, prev_d);
          chk($sformatf("t3.hold_last%0d", c), {31'd0, m00_if.tlast}, {31'd0, prev_l});
        end
        if (m00_if.tready) begin
          chk($sformatf("t3.word%0d", nw), m00_if.tdata, (nw < 4) ? a_w[nw % 4] : b_w[nw % 4]);
          chk($sformatf("t3.last%0d", nw), {31'd0, m00_if.tlast}, (nw == 7) ? 32'd1 : 32'd0);
          nw++;
          have_prev = 1'b0;
        end else begin
          stalls++;
          have_prev = 1'b1;
          prev_d = m00_if.tdata;
          prev_l = m00_if.tlast;
        end
      end
      cyc();
      if (take) begin
        if (nacc == 1) blk_data = BLK_B;
        else blk_valid = 1'b0;
      end
    end
    m00_if.tready = 1'b0; blk_valid = 1'b0;
    chk("t3.words", nw, 32'd8);
    #2;
    chk("t3.busy_end", {31'd0, pkt_busy}, 32'd0);
`ifdef AXIS_OUT_STATS_EN
    chk("t3.stat_words", stat_words - base_w, 32'd8);
    chk("t3.stat_stalls", stat_stalls - base_s, stalls);
`endif
    cyc();

    // restart request while busy is ignored
    pkt_start = 1'b1; pkt_blocks = 16'd2; blk_valid = 1'b1; blk_data = BLK_A;
    m00_if.tready = 1'b1;
    cyc();
    nw = 0; nl = 0;
    for (int c = 0; c < 60; c++) begin
      pkt_start = (c == 3);
      pkt_blocks = (c == 3) ? 16'd5 : 16'd0;
      #2;
      if (c == 3) chk("t5.busy_mid", {31'd0, pkt_busy}, 32'd1);
      if (m00_if.tvalid && m00_if.tready) begin
        chk($sformatf("t5.word%0d", nw), m00_if.tdata, a_w[nw % 4]);
        if (m00_if.tlast) begin
          nl++;
          chk("t5.last_pos", nw, 32'd7);
        end
        nw++;
      end
      cyc();
    end
    pkt_start = 1'b0; pkt_blocks = '0;
    chk("t5.words", nw, 32'd8);
    chk("t5.lasts", nl, 32'd1);
    #2;
    chk("t5.busy_end", {31'd0, pkt_busy}, 32'd0);
    cyc();

    // asynchronous reset in the middle of block 1
    pkt_start = 1'b1; pkt_blocks = 16'd2; blk_valid = 1'b1; blk_data = BLK_A;
    m00_if.tready = 1'b1;
    cyc();
    pkt_start = 1'b0; pkt_blocks = '0;
    nw = 0; nl = 0;
    for (int c = 0; c < 20 && nw < 2; c++) begin
      #2;
      if (m00_if.tvalid && m00_if.tready) begin
        nw++;
        if (m00_if.tlast) nl++;
      end
      cyc();
    end
    chk("t6.pre_words", nw, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6.busy",   {31'd0, pkt_busy}, 32'd0);
    chk("t6.bready", {31'd0, blk_ready}, 32'd0);
    chk("t6.tvalid", {31'd0, m00_if.tvalid}, 32'd0);
    chk("t6.tlast",  {31'd0, m00_if.tlast}, 32'd0);
    chk("t6.tdata",  m00_if.tdata, 32'd0);
    chk("t6.tstrb",  {28'd0, m00_if.tstrb}, 32'd0);
`ifdef AXIS_OUT_STATS_EN
    chk("t6.stat_words", stat_words, 32'd0);
    chk("t6.stat_stalls", stat_stalls, 32'd0);
`endif
    repeat (3) cyc();
    #2;
    chk("t6.bready_held", {31'd0, blk_ready}, 32'd0);
    chk("t6.tvalid_held", {31'd0, m00_if.tvalid}, 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("t6.no_early_last", nl, 32'd0);
    blk_data = BLK_C; pkt_start = 1'b1; pkt_blocks = 16'd1;
    cyc();
    pkt_start = 1'b0; pkt_blocks = '0;
    nw = 0;
    for (int c = 0; c < 12; c++) begin
      #2;
      if (m00_if.tvalid && m00_if.tready) begin
        chk($sformatf("t6.word%0d", nw), m00_if.tdata, c_w[nw % 4]);
        chk($sformatf("t6.last%0d", nw), {31'd0, m00_if.tlast}, (nw == 3) ? 32'd1 : 32'd0);
        nw++;
      end
      cyc();
    end
    blk_valid = 1'b0;
    chk("t6.words", nw, 32'd4);
    #2;
    chk("t6.busy_end", {31'd0, pkt_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
